regfile_wb_queue: RTL and testbench

//  Write-side feeder for the core register file. It buffers retiring results
//  (ALU results, late cache-load data) in a small in-order FIFO. It drains

---
 rtl/regfile_wb_queue.sv | 130 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file's single write port, with read forwarding.
// Minimum latency is one edge from push to pop. in_ready drops only when the queue is full.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_waddr,
    input  logic [DW-1:0]              in_wdata,
    input  logic                       port_grant,
    output logic                       reg_wr,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata,
    input  logic [AW-1:0]              raddr1,
    input  logic [AW-1:0]              raddr2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DW-1:0]              fwd1,
    output logic [DW-1:0]              fwd2,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_wr_q, reg_wr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic push;
    logic pop;

    assign in_ready = (count_q < CW'(DEPTH));
    // x0 results are acknowledged upstream but never take a slot.
    assign push     = in_valid && in_ready && (in_waddr != '0);
    assign pop      = port_grant && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        reg_wr_d = pop;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            waddr_d  = mem_addr_q[rd_ptr_q];
            wdata_d  = mem_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reg_wr_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            reg_wr_q <= reg_wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= in_waddr;
            mem_data_q[wr_ptr_q] <= in_wdata;
        end
    end

    // Lowest priority first (output stage), then oldest to youngest so younger matches overwrite.
    always_comb begin
        hit1 = 1'b0;
        fwd1 = '0;
        hit2 = 1'b0;
        fwd2 = '0;
        if (reg_wr_q && (waddr_q == raddr1)) begin
            hit1 = 1'b1;
            fwd1 = wdata_q;
        end
        if (reg_wr_q && (waddr_q == raddr2)) begin
            hit2 = 1'b1;
            fwd2 = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (mem_addr_q[rd_ptr_q + PW'(i)] == raddr1) begin
                    hit1 = 1'b1;
                    fwd1 = mem_data_q[rd_ptr_q + PW'(i)];
                end
                if (mem_addr_q[rd_ptr_q + PW'(i)] == raddr2) begin
                    hit2 = 1'b1;
                    fwd2 = mem_data_q[rd_ptr_q + PW'(i)];
                end
            end
        end
        if (raddr1 == '0) begin
            hit1 = 1'b0;
            fwd1 = '0;
        end
        if (raddr2 == '0) begin
            hit2 = 1'b0;
            fwd2 = '0;
        end
    end

    assign reg_wr = reg_wr_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign count  = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, single write, backpressure, forwarding, x0, concurrency.
module tb_regfile_wb_queue;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        port_grant;
    logic        reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .port_grant (port_grant),
        .reg_wr     (reg_wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .hit1       (hit1),
        .hit2       (hit2),
        .fwd1       (fwd1),
        .fwd2       (fwd2),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_waddr = a;
        in_wdata = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_waddr   = '0;
        in_wdata   = '0;
        port_grant = 1'b0;
        raddr1     = '0;
        raddr2     = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: reset mid-drain
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        push(5'd3, 32'h33);
        check("t1_count3", 32'(count), 32'd3);
        port_grant = 1'b1;
        tick();
        check("t1_reg_wr_pre", 32'(reg_wr), 32'd1);
        port_grant = 1'b0;
        raddr1 = 5'd2;
        raddr2 = 5'd1;
        #1;
        check("t1_hit1_pre", 32'(hit1), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t1_reg_wr", 32'(reg_wr), 32'd0);
        check("t1_count", 32'(count), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_hit1", 32'(hit1), 32'd0);
        check("t1_hit2", 32'(hit2), 32'd0);
        check("t1_waddr", 32'(waddr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Test 2: single write latency and forwarding window
        port_grant = 1'b1;
        raddr1 = 5'd5;
        raddr2 = 5'd0;
        push(5'd5, 32'hDEADBEEF);
        check("t2_e0_reg_wr", 32'(reg_wr), 32'd0);
        check("t2_e0_hit1", 32'(hit1), 32'd1);
        check("t2_e0_fwd1", fwd1, 32'hDEADBEEF);
        tick();
        check("t2_e1_reg_wr", 32'(reg_wr), 32'd1);
        check("t2_e1_waddr", 32'(waddr), 32'd5);
        check("t2_e1_wdata", wdata, 32'hDEADBEEF);
        check("t2_e1_hit1", 32'(hit1), 32'd1);
        check("t2_e1_fwd1", fwd1, 32'hDEADBEEF);
        tick();
        check("t2_e2_reg_wr", 32'(reg_wr), 32'd0);
        check("t2_e2_hit1", 32'(hit1), 32'd0);
        check("t2_e2_fwd1", fwd1, 32'd0);

        // Test 3: full queue and backpressure
        port_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 32'h100 + 32'(i));
        end
        check("t3_count_full", 32'(count), 32'd4);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_waddr = 5'd5;
        in_wdata = 32'h105;
        tick();
        check("t3_count_held", 32'(count), 32'd4);
        port_grant = 1'b1;
        tick();
        check("t3_pop1_waddr", 32'(waddr), 32'd1);
        check("t3_pop1_count", 32'(count), 32'd3);
        check("t3_pop1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_pop2_waddr", 32'(waddr), 32'd2);
        check("t3_pop2_count", 32'(count), 32'd3);
        tick();
        check("t3_pop3_waddr", 32'(waddr), 32'd3);
        tick();
        check("t3_pop4_waddr", 32'(waddr), 32'd4);
        tick();
        check("t3_pop5_waddr", 32'(waddr), 32'd5);
        check("t3_pop5_wdata", wdata, 32'h105);
        check("t3_pop5_reg_wr", 32'(reg_wr), 32'd1);
        tick();
        check("t3_idle_reg_wr", 32'(reg_wr), 32'd0);
        check("t3_idle_count", 32'(count), 32'd0);

        // Test 4: forwarding priority across queue and output stage
        port_grant = 1'b0;
        raddr1 = 5'd7;
        push(5'd7, 32'd1);
        push(5'd7, 32'd2);
        check("t4_fwd_young", fwd1, 32'd2);
        port_grant = 1'b1;
        tick();
        check("t4_pop1_reg_wr", 32'(reg_wr), 32'd1);
        check("t4_pop1_wdata", wdata, 32'd1);
        check("t4_pop1_fwd", fwd1, 32'd2);
        tick();
        check("t4_pop2_fwd", fwd1, 32'd2);
        check("t4_pop2_hit", 32'(hit1), 32'd1);
        tick();
        check("t4_drained_hit", 32'(hit1), 32'd0);

        // Test 5: x0 writes are consumed without effect
        raddr2 = 5'd0;
        in_valid = 1'b1;
        in_waddr = 5'd0;
        in_wdata = 32'hFFFF_FFFF;
        #1;
        check("t5_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t5_count", 32'(count), 32'd0);
        check("t5_hit2", 32'(hit2), 32'd0);
        tick();
        check("t5_reg_wr", 32'(reg_wr), 32'd0);

        // Test 6: push and pop on the same edge
        port_grant = 1'b0;
        raddr2 = 5'd9;
        push(5'd10, 32'hA);
        push(5'd11, 32'hB);
        check("t6_count2", 32'(count), 32'd2);
        port_grant = 1'b1;
        push(5'd9, 32'h55);
        check("t6_count_same", 32'(count), 32'd2);
        check("t6_pop1_waddr", 32'(waddr), 32'd10);
        check("t6_hit2", 32'(hit2), 32'd1);
        check("t6_fwd2", fwd2, 32'h55);
        tick();
        check("t6_pop2_waddr", 32'(waddr), 32'd11);
        check("t6_pop2_count", 32'(count), 32'd1);
        tick();
        check("t6_pop3_waddr", 32'(waddr), 32'd9);
        check("t6_pop3_wdata", wdata, 32'h55);
        check("t6_pop3_count", 32'(count), 32'd0);
        tick();
        check("t6_idle_reg_wr", 32'(reg_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
